// File: rtl/instructions_pkg.sv
// instructions_pkg: shared M-extension operation codes and sequencer state
// encoding for the multi-cycle multiply/divide unit.
package instructions_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } e_md_op;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } e_md_state;

    // rs1 is interpreted as signed for these ops
    function automatic logic op_a_signed(input e_md_op op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    // rs2 is interpreted as signed for these ops
    function automatic logic op_b_signed(input e_md_op op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/md_step.sv
// md_step: one radix-2 iteration on the {hi, lo} accumulator.
//   multiply: lo holds the remaining multiplier bits, hi the partial product;
//             conditionally add the multiplicand to hi, then shift right.
//   divide:   hi holds the partial remainder, lo the dividend/quotient bits;
//             shift left, trial-subtract the divisor, restore on borrow.
module md_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic                i_div,
    input  logic [2*XLEN-1:0]   i_acc,
    input  logic [XLEN-1:0]     i_opb,
    output logic [2*XLEN-1:0]   o_acc
);

    logic [XLEN:0] w_sum;
    logic [XLEN:0] w_rsh;
    logic [XLEN:0] w_diff;

    // single shift-add / shift-subtract step
    always_comb begin
        w_sum  = {1'b0, i_acc[2*XLEN-1:XLEN]} + {1'b0, i_opb};
        w_rsh  = i_acc[2*XLEN-1:XLEN-1];
        w_diff = w_rsh - {1'b0, i_opb};
        o_acc  = i_acc;
        if (i_div) begin
            if (!w_diff[XLEN]) begin
                o_acc = {w_diff[XLEN-1:0], i_acc[XLEN-2:0], 1'b1};
            end else begin
                o_acc = {w_rsh[XLEN-1:0], i_acc[XLEN-2:0], 1'b0};
            end
        end else begin
            if (i_acc[0]) begin
                o_acc = {w_sum, i_acc[XLEN-1:1]};
            end else begin
                o_acc = {1'b0, i_acc[2*XLEN-1:1]};
            end
        end
    end

endmodule

// File: rtl/md_sequencer.sv
// md_sequencer: multi-cycle RV32M multiply/divide unit for the Execute stage.
// Iterates on operand magnitudes for XLEN cycles, applies the sign fix,
// then issues a single result pulse. Holds Execute stalled while busy.
// Optional: define MD_EARLY_OUT_EN to finish zero-operand multiplies and
// divides with |a| < |b| directly at accept.
module md_sequencer
    import instructions_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned REG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [XLEN-1:0]  req_a,
    input  logic [XLEN-1:0]  req_b,
    input  logic [REG_W-1:0] req_rd,
    input  logic             flush,
    output logic             stall_exe,
    output logic             rsp_valid,
    output logic [XLEN-1:0]  rsp_data,
    output logic [REG_W-1:0] rsp_rd
);

    localparam int unsigned       CNT_W    = $clog2(XLEN);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]   INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    e_md_state          r_state;
    e_md_op             r_op;
    logic [REG_W-1:0]   r_rd;
    logic [2*XLEN-1:0]  r_acc;
    logic [XLEN-1:0]    r_opb;
    logic               r_neg;
    logic [CNT_W-1:0]   r_cnt;
    logic [XLEN-1:0]    r_rsp_data;
    logic [REG_W-1:0]   r_rsp_rd;

    e_md_op             w_op;
    logic               w_accept;
    logic               w_is_div;
    logic               w_is_rem;
    logic               w_neg_a;
    logic               w_neg_b;
    logic               w_res_neg;
    logic [XLEN-1:0]    w_mag_a;
    logic [XLEN-1:0]    w_mag_b;
    logic               w_special;
    logic [XLEN-1:0]    w_special_data;
    logic [2*XLEN-1:0]  w_step_acc;
    logic [2*XLEN-1:0]  w_prod;
    logic [XLEN-1:0]    w_div_src;
    logic [XLEN-1:0]    w_fix_data;

    assign req_ready = (r_state == IDLE) & ~flush & ~rst;
    assign stall_exe = (r_state == CALC) | (r_state == FIX);
    assign rsp_valid = (r_state == DONE);
    assign rsp_data  = r_rsp_data;
    assign rsp_rd    = r_rsp_rd;

    // request decode: magnitudes, result sign and shortcut results
    always_comb begin
        w_op      = e_md_op'(req_op);
        w_accept  = req_valid & req_ready;
        w_is_div  = req_op[2];
        w_is_rem  = req_op[2] & req_op[1];
        w_neg_a   = op_a_signed(w_op) & req_a[XLEN-1];
        w_neg_b   = op_b_signed(w_op) & req_b[XLEN-1];
        w_mag_a   = w_neg_a ? -req_a : req_a;
        w_mag_b   = w_neg_b ? -req_b : req_b;
        // remainder follows the dividend; product and quotient follow sign mismatch
        w_res_neg = w_is_rem ? w_neg_a : (w_neg_a ^ w_neg_b);

        w_special      = 1'b0;
        w_special_data = '0;
        if (w_is_div && (req_b == '0)) begin
            w_special      = 1'b1;
            w_special_data = w_is_rem ? req_a : '1;
        end else if (((w_op == OP_DIV) || (w_op == OP_REM)) &&
                     (req_a == INT_MIN) && (req_b == '1)) begin
            w_special      = 1'b1;
            w_special_data = w_is_rem ? '0 : INT_MIN;
        end
`ifdef MD_EARLY_OUT_EN
        else if (!w_is_div && ((req_a == '0) || (req_b == '0))) begin
            w_special      = 1'b1;
            w_special_data = '0;
        end else if (w_is_div && (w_mag_a < w_mag_b)) begin
            w_special      = 1'b1;
            w_special_data = w_is_rem ? req_a : '0;
        end
`endif
    end

    md_step #(.XLEN(XLEN)) u_step (
        .i_div (r_op[2]),
        .i_acc (r_acc),
        .i_opb (r_opb),
        .o_acc (w_step_acc)
    );

    // sign fix and half selection applied in FIX
    always_comb begin
        w_prod     = r_neg ? -r_acc : r_acc;
        w_div_src  = r_op[1] ? r_acc[2*XLEN-1:XLEN] : r_acc[XLEN-1:0];
        w_fix_data = '0;
        if (r_op[2]) begin
            w_fix_data = r_neg ? -w_div_src : w_div_src;
        end else if (r_op == OP_MUL) begin
            w_fix_data = w_prod[XLEN-1:0];
        end else begin
            w_fix_data = w_prod[2*XLEN-1:XLEN];
        end
    end

    // sequencing FSM, iteration counter and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_op       <= OP_MUL;
            r_rd       <= '0;
            r_acc      <= '0;
            r_opb      <= '0;
            r_neg      <= 1'b0;
            r_cnt      <= '0;
            r_rsp_data <= '0;
            r_rsp_rd   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op  <= w_op;
                        r_rd  <= req_rd;
                        r_neg <= w_res_neg;
                        r_opb <= w_mag_b;
                        r_acc <= {{XLEN{1'b0}}, w_mag_a};
                        r_cnt <= '0;
                        if (w_special) begin
                            r_rsp_data <= w_special_data;
                            r_rsp_rd   <= req_rd;
                            r_state    <= DONE;
                        end else begin
                            r_state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (flush) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_acc <= w_step_acc;
                        if (r_cnt == LAST_CNT) begin
                            r_cnt   <= '0;
                            r_state <= FIX;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                FIX: begin
                    if (flush) begin
                        r_state <= IDLE;
                    end else begin
                        r_rsp_data <= w_fix_data;
                        r_rsp_rd   <= r_rd;
                        r_state    <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_sequencer.sv
// tb_md_sequencer: scoreboard bench for md_sequencer. The driver pushes the
// expected result, destination and response cycle on each accept; a monitor
// pops and compares whenever rsp_valid is seen.
module tb_md_sequencer;

    localparam int unsigned NORM_LAT = 34;
`ifdef MD_EARLY_OUT_EN
    localparam int unsigned EO_LAT = 1;
`else
    localparam int unsigned EO_LAT = NORM_LAT;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [4:0]  req_rd;
    logic        flush;
    logic        stall_exe;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_rd;

    typedef struct {
        string       name;
        logic [31:0] data;
        logic [4:0]  rd;
        int unsigned cyc;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned cyc      = 0;
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    md_sequencer #(.XLEN(32), .REG_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_rd    (req_rd),
        .flush     (flush),
        .stall_exe (stall_exe),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_rd    (rsp_rd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor: every response must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rsp_valid) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rsp: got data 0x%08h rd %0d with nothing outstanding (cycle %0d)",
                         rsp_data, rsp_rd, cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk({e.name, "_data"}, rsp_data, e.data);
                chk({e.name, "_rd"}, {27'd0, rsp_rd}, {27'd0, e.rd});
                chk({e.name, "_cycle"}, cyc, e.cyc);
                chk({e.name, "_ready_in_done"}, {31'd0, req_ready}, 32'd0);
            end
        end
    end

    // drive one request; returns #1 after the accept edge (cycle 1)
    task automatic issue(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                         input int unsigned lat, input bit push);
        int unsigned n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk({name, "_ready_timeout"}, {31'd0, req_ready}, 32'd1);
            return;
        end
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_rd    = rd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (push) begin
            e.name = name;
            e.data = exp;
            e.rd   = rd;
            e.cyc  = cyc + lat - 1;
            sb_q.push_back(e);
        end
    endtask

    initial begin
        int unsigned n;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = 3'd0;
        req_a     = '0;
        req_b     = '0;
        req_rd    = '0;
        flush     = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_stall", {31'd0, stall_exe}, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_rd", {27'd0, rsp_rd}, 32'd0);
        chk("rst_ready_low", {31'd0, req_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", {31'd0, req_ready}, 32'd1);

        // MUL with stall profile: high cycles 1..33, low in DONE
        issue("mul_7_m3", 3'd0, 32'd7, 32'hFFFFFFFD, 5'd1, 32'hFFFFFFEB, NORM_LAT, 1'b1);
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            chk("mul_stall", {31'd0, stall_exe}, (k <= 33) ? 32'd1 : 32'd0);
        end

        issue("mulhu", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'hFFFFFFFE, NORM_LAT, 1'b1);
        issue("mulh", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'h00000000, NORM_LAT, 1'b1);
        issue("mulhsu", 3'd2, 32'hFFFFFFFF, 32'd2, 5'd4, 32'hFFFFFFFF, NORM_LAT, 1'b1);
        issue("div_m7_2", 3'd4, 32'hFFFFFFF9, 32'd2, 5'd5, 32'hFFFFFFFD, NORM_LAT, 1'b1);
        issue("rem_m7_2", 3'd6, 32'hFFFFFFF9, 32'd2, 5'd6, 32'hFFFFFFFF, NORM_LAT, 1'b1);
        issue("divu_100_7", 3'd5, 32'd100, 32'd7, 5'd7, 32'd14, NORM_LAT, 1'b1);
        issue("remu_100_7", 3'd7, 32'd100, 32'd7, 5'd8, 32'd2, NORM_LAT, 1'b1);

        // special cases finish one cycle after accept with no stall
        issue("divu_by0", 3'd5, 32'd5, 32'd0, 5'd9, 32'hFFFFFFFF, 1, 1'b1);
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            chk("divu_by0_stall", {31'd0, stall_exe}, 32'd0);
        end
        issue("rem_by0", 3'd6, 32'd5, 32'd0, 5'd10, 32'd5, 1, 1'b1);
        issue("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h80000000, 1, 1'b1);
        issue("rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'd0, 1, 1'b1);

        // early-out eligible operands: same results in either build
        issue("mul_zero", 3'd0, 32'd0, 32'd12345, 5'd13, 32'd0, EO_LAT, 1'b1);
        issue("divu_small", 3'd5, 32'd3, 32'd10, 5'd14, 32'd0, EO_LAT, 1'b1);
        issue("rem_small", 3'd6, 32'hFFFFFFFD, 32'd10, 5'd15, 32'hFFFFFFFD, EO_LAT, 1'b1);

        // flush mid-CALC: no response, ready again next cycle
        issue("div_flushed", 3'd4, 32'd1000, 32'd7, 5'd16, 32'd0, NORM_LAT, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_cycle_stall", {31'd0, stall_exe}, 32'd1);
        chk("flush_cycle_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("after_flush_ready", {31'd0, req_ready}, 32'd1);
        chk("after_flush_stall", {31'd0, stall_exe}, 32'd0);
        chk("after_flush_rsp", {31'd0, rsp_valid}, 32'd0);
        issue("mul_3_4", 3'd0, 32'd3, 32'd4, 5'd17, 32'd12, NORM_LAT, 1'b1);

        // reset mid-CALC with a request held
        issue("div_reset", 3'd5, 32'd1000, 32'd3, 5'd18, 32'd0, NORM_LAT, 1'b0);
        repeat (19) @(posedge clk);
        #1;
        rst       = 1'b1;
        req_valid = 1'b1;
        req_op    = 3'd0;
        req_a     = 32'd3;
        req_b     = 32'd4;
        req_rd    = 5'd19;
        @(negedge clk);
        chk("rst_hold_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("midrst_stall", {31'd0, stall_exe}, 32'd0);
        chk("midrst_rsp_data", rsp_data, 32'd0);
        chk("midrst_rsp_rd", {27'd0, rsp_rd}, 32'd0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
        chk("post_rst_stall", {31'd0, stall_exe}, 32'd0);

        // drain the scoreboard, then watch for stray responses
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        while (sb_q.size() != 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk({e.name, "_no_rsp_timeout"}, 32'd0, 32'd1);
        end
        repeat (40) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no completion expected finish");
        $fatal(1);
    end

endmodule
